// File: rtl/tictactoe_pkg.sv
// Shared definitions for the tic-tac-toe datapath: cell codes, board size,
// controller states and a helper to find the opponent of a player.
package tictactoe_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam int NUM_CELLS = 9;

    typedef enum logic [1:0] {
        TURN_X    = 2'b00,
        TURN_O    = 2'b01,
        CHECK     = 2'b10,
        GAME_OVER = 2'b11
    } state_t;

    // Opponent of the given player; anything that is not X maps to X so an
    // uninitialised mover still yields a legal cell code.
    function automatic logic [1:0] other_player(input logic [1:0] player);
        logic [1:0] result;
        if (player == CELL_X) begin
            result = CELL_O;
        end else begin
            result = CELL_X;
        end
        return result;
    endfunction

endpackage

// File: rtl/move_pos_decoder.sv
// Maps a 4-bit board position (1..9) to a one-hot cell write enable.
// Positions outside 1..9 give an all-zero enable and pos_in_range = 0.
module move_pos_decoder
    import tictactoe_pkg::*;
(
    input  logic [3:0] move_pos,
    output logic [8:0] cell_we,
    output logic       pos_in_range
);

    // One-hot decode of the requested cell
    always_comb begin
        cell_we      = 9'b0_0000_0000;
        pos_in_range = 1'b0;
        case (move_pos)
            4'd1:    begin cell_we = 9'b0_0000_0001; pos_in_range = 1'b1; end
            4'd2:    begin cell_we = 9'b0_0000_0010; pos_in_range = 1'b1; end
            4'd3:    begin cell_we = 9'b0_0000_0100; pos_in_range = 1'b1; end
            4'd4:    begin cell_we = 9'b0_0000_1000; pos_in_range = 1'b1; end
            4'd5:    begin cell_we = 9'b0_0001_0000; pos_in_range = 1'b1; end
            4'd6:    begin cell_we = 9'b0_0010_0000; pos_in_range = 1'b1; end
            4'd7:    begin cell_we = 9'b0_0100_0000; pos_in_range = 1'b1; end
            4'd8:    begin cell_we = 9'b0_1000_0000; pos_in_range = 1'b1; end
            4'd9:    begin cell_we = 9'b1_0000_0000; pos_in_range = 1'b1; end
            default: begin cell_we = 9'b0_0000_0000; pos_in_range = 1'b0; end
        endcase
    end

endmodule

// File: rtl/tictactoe_board_ctrl.sv
// Board-state and turn controller. Holds the nine cell registers feeding the
// win / no-space detectors, accepts one legal move per handshake, alternates
// players and resolves win / draw / next turn one cycle after each move.
module tictactoe_board_ctrl
    import tictactoe_pkg::*;
#(
    parameter logic [1:0] FIRST_PLAYER = 2'b01
)
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic       move_ready,
    output logic       move_illegal,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    input  logic [1:0] win_in,
    input  logic       no_space,
    output logic [1:0] turn,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       draw
);

    localparam state_t START_STATE = (FIRST_PLAYER == CELL_X) ? TURN_X : TURN_O;

    state_t     state_r;
    state_t     state_s;
    logic [1:0] board_r [NUM_CELLS];
    logic [1:0] mover_r;
    logic [1:0] winner_r;
    logic       move_illegal_r;

    logic [8:0] cell_we_s;
    logic       pos_in_range_s;
    logic       cell_empty_s;
    logic       move_req_s;
    logic       move_accept_s;
    logic       move_reject_s;
    logic [1:0] cur_player_s;

    move_pos_decoder u_move_pos_decoder (
        .move_pos     (move_pos),
        .cell_we      (cell_we_s),
        .pos_in_range (pos_in_range_s)
    );

    // Is the addressed cell free? Out-of-range positions select no cell and
    // are rejected separately through pos_in_range_s.
    always_comb begin
        cell_empty_s = 1'b1;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (cell_we_s[i] && (board_r[i] != CELL_EMPTY)) begin
                cell_empty_s = 1'b0;
            end else begin
                cell_empty_s = cell_empty_s;
            end
        end
    end

    // Move handshake: only TURN states accept requests; others ignore them
    always_comb begin
        move_req_s   = 1'b0;
        cur_player_s = CELL_X;
        case (state_r)
            TURN_X: begin
                move_req_s   = move_valid;
                cur_player_s = CELL_X;
            end
            TURN_O: begin
                move_req_s   = move_valid;
                cur_player_s = CELL_O;
            end
            default: begin
                move_req_s   = 1'b0;
                cur_player_s = CELL_X;
            end
        endcase
        move_accept_s = move_req_s && pos_in_range_s && cell_empty_s;
        move_reject_s = move_req_s && !move_accept_s;
    end

    // Next-state logic; win beats draw when both are reported in CHECK
    always_comb begin
        state_s = state_r;
        case (state_r)
            TURN_X, TURN_O: begin
                if (move_accept_s) begin
                    state_s = CHECK;
                end else begin
                    state_s = state_r;
                end
            end
            CHECK: begin
                if (win_in != CELL_EMPTY) begin
                    state_s = GAME_OVER;
                end else if (no_space) begin
                    state_s = GAME_OVER;
                end else if (other_player(mover_r) == CELL_O) begin
                    state_s = TURN_O;
                end else begin
                    state_s = TURN_X;
                end
            end
            GAME_OVER: begin
                state_s = GAME_OVER;
            end
            default: begin
                state_s = START_STATE;
            end
        endcase
    end

    // Status outputs decoded straight from the state register
    always_comb begin
        move_ready = 1'b0;
        turn       = CELL_EMPTY;
        game_over  = 1'b0;
        draw       = 1'b0;
        case (state_r)
            TURN_X: begin
                move_ready = 1'b1;
                turn       = CELL_X;
            end
            TURN_O: begin
                move_ready = 1'b1;
                turn       = CELL_O;
            end
            CHECK: begin
                turn = other_player(mover_r);
            end
            GAME_OVER: begin
                game_over = 1'b1;
                draw      = (winner_r == CELL_EMPTY);
            end
            default: begin
                move_ready = 1'b0;
                turn       = CELL_EMPTY;
            end
        endcase
    end

    // State, board, mover, winner and illegal-pulse registers; reset and
    // new_game both clear everything and discard any concurrent move
    always_ff @(posedge clock) begin
        if (!reset_n || new_game) begin
            state_r        <= START_STATE;
            mover_r        <= CELL_EMPTY;
            winner_r       <= CELL_EMPTY;
            move_illegal_r <= 1'b0;
            for (int i = 0; i < NUM_CELLS; i++) begin
                board_r[i] <= CELL_EMPTY;
            end
        end else begin
            state_r        <= state_s;
            move_illegal_r <= move_reject_s;
            for (int i = 0; i < NUM_CELLS; i++) begin
                if (move_accept_s && cell_we_s[i]) begin
                    board_r[i] <= cur_player_s;
                end else begin
                    board_r[i] <= board_r[i];
                end
            end
            if (move_accept_s) begin
                mover_r <= cur_player_s;
            end else begin
                mover_r <= mover_r;
            end
            // Entering GAME_OVER: win_in is the winner, or 00 for a draw
            if ((state_r == CHECK) && (state_s == GAME_OVER)) begin
                winner_r <= win_in;
            end else begin
                winner_r <= winner_r;
            end
        end
    end

    assign move_illegal = move_illegal_r;
    assign winner       = winner_r;
    assign pos1         = board_r[0];
    assign pos2         = board_r[1];
    assign pos3         = board_r[2];
    assign pos4         = board_r[3];
    assign pos5         = board_r[4];
    assign pos6         = board_r[5];
    assign pos7         = board_r[6];
    assign pos8         = board_r[7];
    assign pos9         = board_r[8];

endmodule

// File: tb/tb_tictactoe_board_ctrl.sv
// Testbench for tictactoe_board_ctrl: directed table of cycles with
// constant expectations, a FIRST_PLAYER=O instance checked by hand, and a
// randomized run against a game-rules reference model.
module tb_tictactoe_board_ctrl;

    logic        clock = 1'b0;
    logic        reset_n, new_game, move_valid, no_space;
    logic [3:0]  move_pos;
    logic [1:0]  win_in;
    logic        move_ready, move_illegal, game_over, draw;
    logic [1:0]  turn, winner;
    logic [17:0] bv;

    logic        new_game2, move_valid2, no_space2;
    logic [3:0]  move_pos2;
    logic [1:0]  win_in2;
    logic        move_ready2, move_illegal2, game_over2, draw2;
    logic [1:0]  turn2, winner2;
    logic [17:0] b2v;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    tictactoe_board_ctrl dut (
        .clock(clock), .reset_n(reset_n), .new_game(new_game),
        .move_valid(move_valid), .move_pos(move_pos),
        .move_ready(move_ready), .move_illegal(move_illegal),
        .pos1(bv[1:0]), .pos2(bv[3:2]), .pos3(bv[5:4]), .pos4(bv[7:6]),
        .pos5(bv[9:8]), .pos6(bv[11:10]), .pos7(bv[13:12]), .pos8(bv[15:14]),
        .pos9(bv[17:16]),
        .win_in(win_in), .no_space(no_space), .turn(turn),
        .game_over(game_over), .winner(winner), .draw(draw)
    );

    tictactoe_board_ctrl #(.FIRST_PLAYER(2'b10)) dut_o (
        .clock(clock), .reset_n(reset_n), .new_game(new_game2),
        .move_valid(move_valid2), .move_pos(move_pos2),
        .move_ready(move_ready2), .move_illegal(move_illegal2),
        .pos1(b2v[1:0]), .pos2(b2v[3:2]), .pos3(b2v[5:4]), .pos4(b2v[7:6]),
        .pos5(b2v[9:8]), .pos6(b2v[11:10]), .pos7(b2v[13:12]), .pos8(b2v[15:14]),
        .pos9(b2v[17:16]),
        .win_in(win_in2), .no_space(no_space2), .turn(turn2),
        .game_over(game_over2), .winner(winner2), .draw(draw2)
    );

    // Reference model: board, phase of play, whose turn, last mover, result
    localparam int PH_READY = 0;
    localparam int PH_CHECK = 1;
    localparam int PH_OVER  = 2;
    logic [17:0] m_board;
    int          m_phase;
    logic [1:0]  m_turn, m_mover, m_winner;
    logic        m_ill;

    typedef struct {
        logic       v;
        logic [3:0] p;
        logic       ng;
        logic [1:0] w;
        logic       ns;
        logic       e_ready;
        logic [1:0] e_turn;
        logic       e_ill;
        logic       e_over;
        logic [1:0] e_win;
        logic       e_draw;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] opp(input logic [1:0] p);
        return (p == 2'b01) ? 2'b10 : 2'b01;
    endfunction

    // Winner code of any completed line on a board, 00 if none
    function automatic logic [1:0] line_win(input logic [17:0] b);
        int lines [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                             '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
        logic [1:0] a, c, d;
        for (int l = 0; l < 8; l++) begin
            a = b[2*lines[l][0]-2 +: 2];
            c = b[2*lines[l][1]-2 +: 2];
            d = b[2*lines[l][2]-2 +: 2];
            if (a != 2'b00 && a == c && a == d) return a;
        end
        return 2'b00;
    endfunction

    function automatic logic board_full(input logic [17:0] b);
        for (int k = 0; k < 9; k++) begin
            if (b[2*k +: 2] == 2'b00) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock cycle on the main instance: drive, predict, then compare
    task automatic step(input logic rst, input logic ng, input logic v, input logic [3:0] p,
                        input logic [1:0] w, input logic ns);
        int pi;
        logic [1:0] e_turn;
        reset_n = ~rst; new_game = ng; move_valid = v; move_pos = p;
        win_in = w; no_space = ns;
        pi = int'(p);
        if (rst || ng) begin
            m_board = '0; m_phase = PH_READY; m_turn = 2'b01;
            m_mover = 2'b00; m_winner = 2'b00; m_ill = 1'b0;
        end else begin
            m_ill = 1'b0;
            if (m_phase == PH_READY) begin
                if (v) begin
                    if (pi >= 1 && pi <= 9 && m_board[2*pi-2 +: 2] == 2'b00) begin
                        m_board[2*pi-2 +: 2] = m_turn;
                        m_mover = m_turn;
                        m_phase = PH_CHECK;
                    end else begin
                        m_ill = 1'b1;
                    end
                end
            end else if (m_phase == PH_CHECK) begin
                if (w != 2'b00) begin
                    m_phase = PH_OVER; m_winner = w;
                end else if (ns) begin
                    m_phase = PH_OVER; m_winner = 2'b00;
                end else begin
                    m_phase = PH_READY; m_turn = opp(m_mover);
                end
            end
        end
        @(posedge clock);
        #1;
        e_turn = (m_phase == PH_READY) ? m_turn : (m_phase == PH_CHECK) ? opp(m_mover) : 2'b00;
        check("model", {move_ready, turn, move_illegal, game_over, winner, draw, bv},
              {(m_phase == PH_READY), e_turn, m_ill, (m_phase == PH_OVER), m_winner,
               (m_phase == PH_OVER && m_winner == 2'b00), m_board});
    endtask

    task automatic add(input logic v, input logic [3:0] p, input logic ng, input logic [1:0] w,
                       input logic ns, input logic er, input logic [1:0] et, input logic ei,
                       input logic eo, input logic [1:0] ew, input logic ed);
        vec_t r;
        r.v = v; r.p = p; r.ng = ng; r.w = w; r.ns = ns;
        r.e_ready = er; r.e_turn = et; r.e_ill = ei; r.e_over = eo; r.e_win = ew; r.e_draw = ed;
        tbl.push_back(r);
    endtask

    // Nine alternating moves X-first; the last CHECK sees no_space=1 and fw
    task automatic add_full_game(input logic [1:0] fw);
        int mv [9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
        logic [1:0] nxt;
        for (int i = 0; i < 9; i++) begin
            nxt = (i % 2 == 0) ? 2'b10 : 2'b01;
            add(1'b1, 4'(mv[i]), 1'b0, 2'b00, 1'b0, 1'b0, nxt, 1'b0, 1'b0, 2'b00, 1'b0);
            if (i < 8) begin
                add(1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b1, nxt, 1'b0, 1'b0, 2'b00, 1'b0);
            end else begin
                add(1'b0, 4'd0, 1'b0, fw, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, fw, (fw == 2'b00));
            end
        end
    endtask

    int win_row;

    initial begin
        reset_n = 1'b0; new_game = 1'b0; move_valid = 1'b0; move_pos = 4'd0;
        win_in = 2'b00; no_space = 1'b0;
        new_game2 = 1'b0; move_valid2 = 1'b0; move_pos2 = 4'd0; win_in2 = 2'b00; no_space2 = 1'b0;
        @(posedge clock); #1;
        step(1'b1, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0);
        step(1'b1, 1'b0, 1'b1, 4'd5, 2'b11, 1'b1);

        // FIRST_PLAYER = O instance, while the main instance idles in TURN_X
        step(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0);
        check("fp_reset", {move_ready2, turn2, move_illegal2, game_over2}, {1'b1, 2'b10, 1'b0, 1'b0});
        move_valid2 = 1'b1; move_pos2 = 4'd4;
        step(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0);
        check("fp_first_write", {b2v[7:6], move_ready2, turn2}, {2'b10, 1'b0, 2'b01});
        move_pos2 = 4'd5;
        step(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0);
        check("fp_valid_in_check", {b2v[9:8], move_ready2, turn2, move_illegal2}, {2'b00, 1'b1, 2'b01, 1'b0});
        step(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0);
        check("fp_x_write", {b2v[9:8], move_ready2}, {2'b01, 1'b0});
        move_pos2 = 4'd6; win_in2 = 2'b01;
        step(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0);
        check("fp_over", {game_over2, winner2, draw2, turn2, move_ready2}, {1'b1, 2'b01, 1'b0, 2'b00, 1'b0});
        win_in2 = 2'b00;
        step(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0);
        check("fp_valid_in_over", {b2v[11:10], move_illegal2, game_over2, winner2}, {2'b00, 1'b0, 1'b1, 2'b01});
        move_valid2 = 1'b0;

        // Directed table: X wins via 2-5-8, then illegal moves, new_game cases
        add(1'b1, 4'd5, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0);
        add(1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0);
        add(1'b1, 4'd1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);
        add(1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);
        add(1'b1, 4'd9, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0);
        add(1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0);
        add(1'b1, 4'd3, 1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);
        add(1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);
        add(1'b1, 4'd2, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0);
        add(1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0);
        add(1'b1, 4'd7, 1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);
        add(1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);
        add(1'b1, 4'd8, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0);
        add(1'b0, 4'd0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0);
        win_row = tbl.size() - 1;
        add(1'b1, 4'd4, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0);
        add(1'b0, 4'd0, 1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);
        add(1'b1, 4'd5, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0);
        add(1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0);
        add(1'b1, 4'd5, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0);
        add(1'b1, 4'd0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0);
        add(1'b1, 4'd12, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0);
        add(1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0);
        add(1'b1, 4'd3, 1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);
        add(1'b1, 4'd1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0);
        add(1'b0, 4'd0, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);
        add_full_game(2'b00);
        add(1'b0, 4'd0, 1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);
        add_full_game(2'b10);

        for (int i = 0; i < tbl.size(); i++) begin
            step(1'b0, tbl[i].ng, tbl[i].v, tbl[i].p, tbl[i].w, tbl[i].ns);
            check($sformatf("tbl_row%0d", i),
                  {move_ready, turn, move_illegal, game_over, winner, draw},
                  {tbl[i].e_ready, tbl[i].e_turn, tbl[i].e_ill, tbl[i].e_over, tbl[i].e_win, tbl[i].e_draw});
            if (i == win_row) begin
                check("win_line_258", {bv[3:2], bv[9:8], bv[15:14]}, {2'b01, 2'b01, 2'b01});
            end
        end

        // Randomized play against the reference model
        step(1'b0, 1'b1, 1'b0, 4'd0, 2'b00, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            logic r_rst, r_ng, r_v, r_ns;
            logic [3:0] r_p;
            logic [1:0] r_w;
            r_rst = ($urandom_range(0, 199) == 0);
            r_ng  = ($urandom_range(0, 29) == 0);
            r_v   = ($urandom_range(0, 9) < 7);
            r_p   = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 9)) : 4'($urandom_range(0, 15));
            if (m_phase == PH_CHECK && $urandom_range(0, 9) != 0) begin
                r_w  = line_win(m_board);
                r_ns = board_full(m_board);
            end else begin
                r_w  = 2'($urandom_range(0, 3));
                r_ns = 1'($urandom_range(0, 1));
            end
            step(r_rst, r_ng, r_v, r_p, r_w, r_ns);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
